// File: rtl/hazard_control_unit.sv
// hazard_control_unit
//   Pipeline hazard controller for a five-stage MIPS-style core.
//   It selects the forwarding paths for the decode comparator and the execute ALU.
//   It generates stalls and flushes for four hazard sources:
//     - a load-use dependency
//     - a branch operand dependency
//     - the multi-cycle mult/div unit
//     - syscall drain sequencing
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   rs_d, rt_d                    decode-stage source registers
//   rs_e, rt_e                    execute-stage source registers
//   write_reg_{e,m,w}             destination registers per stage
//   reg_write_{e,m,w}             destination write enables per stage
//   mem_to_reg_{e,m}              load indicators in E and M
//   branch_d, pc_src_d            branch in decode / branch taken
//   md_start_e, md_op_d           mult/div issued in E / mult/div-class op in D
//   syscall_e                     syscall in execute
//   stall_f, stall_d              hold PC and F/D register
//   flush_d, flush_e              clear F/D register / D/E register
//   forward_a_d, forward_b_d      decode comparator takes the M-stage result
//   forward_a_e, forward_b_e      ALU operand select (00 RF, 01 W, 10 M)
//   md_busy                       mult/div unit busy
//   syscall_go                    one-cycle syscall execute pulse
//
// Syscall FSM
//   state    | meaning
//   SC_IDLE  | no syscall in flight
//   SC_DRAIN | older instructions drain out of M/W (two cycles)
//   SC_FIRE  | syscall_go asserted for one cycle
module hazard_control_unit #(
  parameter int MD_LATENCY = 32  // legal range 2..63
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] rs_d,
  input  logic [4:0] rt_d,
  input  logic [4:0] rs_e,
  input  logic [4:0] rt_e,
  input  logic [4:0] write_reg_e,
  input  logic [4:0] write_reg_m,
  input  logic [4:0] write_reg_w,
  input  logic       reg_write_e,
  input  logic       reg_write_m,
  input  logic       reg_write_w,
  input  logic       mem_to_reg_e,
  input  logic       mem_to_reg_m,
  input  logic       branch_d,
  input  logic       pc_src_d,
  input  logic       md_start_e,
  input  logic       md_op_d,
  input  logic       syscall_e,
  output logic       stall_f,
  output logic       stall_d,
  output logic       flush_d,
  output logic       flush_e,
  output logic       forward_a_d,
  output logic       forward_b_d,
  output logic [1:0] forward_a_e,
  output logic [1:0] forward_b_e,
  output logic       md_busy,
  output logic       syscall_go
);

  typedef enum logic [1:0] {SC_IDLE, SC_DRAIN, SC_FIRE} sc_state_t;

  sc_state_t  sc_state, sc_state_next;
  logic [1:0] drain_cnt, drain_cnt_next;
  logic [5:0] md_cnt, md_cnt_next;

  logic lw_stall, br_stall, md_stall, sc_stall, any_stall;

  function automatic logic [1:0] alu_fwd(input logic [4:0] src);
    if (src != 5'd0 && src == write_reg_m && reg_write_m)
      return 2'b10;
    else if (src != 5'd0 && src == write_reg_w && reg_write_w)
      return 2'b01;
    else
      return 2'b00;
  endfunction

  function automatic logic dep(input logic [4:0] dst);
    return (dst != 5'd0) && (dst == rs_d || dst == rt_d);
  endfunction

  // Forwarding is purely combinational, including while in reset.
  always_comb begin
    forward_a_e = alu_fwd(rs_e);
    forward_b_e = alu_fwd(rt_e);
    forward_a_d = (rs_d != 5'd0) && (rs_d == write_reg_m) && reg_write_m;
    forward_b_d = (rt_d != 5'd0) && (rt_d == write_reg_m) && reg_write_m;
  end

  assign md_busy = (md_cnt != 6'd0);

  always_comb begin
    lw_stall  = mem_to_reg_e && dep(write_reg_e);
    br_stall  = branch_d && ((reg_write_e && dep(write_reg_e)) ||
                             (mem_to_reg_m && dep(write_reg_m)));
    md_stall  = md_op_d && md_busy;
    sc_stall  = (sc_state != SC_IDLE) || syscall_e;
    any_stall = lw_stall || br_stall || md_stall || sc_stall;
  end

  // Reset forces a bubble into E and suppresses the other pipeline controls.
  always_comb begin
    stall_f    = any_stall && !rst;
    stall_d    = any_stall && !rst;
    flush_e    = any_stall || rst;
    flush_d    = pc_src_d && !any_stall && !rst;
    syscall_go = (sc_state == SC_FIRE) && !rst;
  end

  // A start while busy is ignored; the counter only reloads from zero.
  always_comb begin
    md_cnt_next = md_cnt;
    if (md_cnt != 6'd0)
      md_cnt_next = md_cnt - 6'd1;
    else if (md_start_e)
      md_cnt_next = 6'(MD_LATENCY);
  end

  always_comb begin
    sc_state_next  = sc_state;
    drain_cnt_next = drain_cnt;
    unique case (sc_state)
      SC_IDLE: begin
        if (syscall_e) begin
          sc_state_next  = SC_DRAIN;
          drain_cnt_next = 2'd2;
        end
      end
      SC_DRAIN: begin
        // Leave DRAIN on the cycle the counter steps down to zero.
        if (drain_cnt <= 2'd1) begin
          drain_cnt_next = 2'd0;
          sc_state_next  = SC_FIRE;
        end else begin
          drain_cnt_next = drain_cnt - 2'd1;
        end
      end
      SC_FIRE: sc_state_next = SC_IDLE;
      default: sc_state_next = SC_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sc_state  <= SC_IDLE;
      drain_cnt <= 2'd0;
      md_cnt    <= 6'd0;
    end else begin
      sc_state  <= sc_state_next;
      drain_cnt <= drain_cnt_next;
      md_cnt    <= md_cnt_next;
    end
  end

endmodule

// File: tb/tb_hazard_control_unit.sv
module tb_hazard_control_unit;

  localparam int LAT = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs_d, rt_d, rs_e, rt_e;
  logic [4:0] write_reg_e, write_reg_m, write_reg_w;
  logic       reg_write_e, reg_write_m, reg_write_w;
  logic       mem_to_reg_e, mem_to_reg_m;
  logic       branch_d, pc_src_d, md_start_e, md_op_d, syscall_e;
  logic       stall_f, stall_d, flush_d, flush_e;
  logic       forward_a_d, forward_b_d;
  logic [1:0] forward_a_e, forward_b_e;
  logic       md_busy, syscall_go;

  hazard_control_unit #(.MD_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .rs_d(rs_d), .rt_d(rt_d), .rs_e(rs_e), .rt_e(rt_e),
    .write_reg_e(write_reg_e), .write_reg_m(write_reg_m), .write_reg_w(write_reg_w),
    .reg_write_e(reg_write_e), .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
    .mem_to_reg_e(mem_to_reg_e), .mem_to_reg_m(mem_to_reg_m),
    .branch_d(branch_d), .pc_src_d(pc_src_d),
    .md_start_e(md_start_e), .md_op_d(md_op_d), .syscall_e(syscall_e),
    .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
    .forward_a_d(forward_a_d), .forward_b_d(forward_b_d),
    .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
    .md_busy(md_busy), .syscall_go(syscall_go)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] rs_d, rt_d, rs_e, rt_e, wr_e, wr_m, wr_w;
    logic       rw_e, rw_m, rw_w, m2r_e, m2r_m, br, pc_src;
    logic       e_stall, e_flush_d, e_fa_d, e_fb_d;
    logic [1:0] e_fa_e, e_fb_e;
  } vec_t;

  vec_t  tv[$];
  string tn[$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    rs_d = 0; rt_d = 0; rs_e = 0; rt_e = 0;
    write_reg_e = 0; write_reg_m = 0; write_reg_w = 0;
    reg_write_e = 0; reg_write_m = 0; reg_write_w = 0;
    mem_to_reg_e = 0; mem_to_reg_m = 0;
    branch_d = 0; pc_src_d = 0; md_start_e = 0; md_op_d = 0; syscall_e = 0;
  endtask

  task automatic add(input string name, input vec_t v);
    tv.push_back(v);
    tn.push_back(name);
  endtask

  task automatic build_vectors();
    vec_t v;
    v = '0; v.rs_e = 5; v.wr_m = 5; v.rw_m = 1; v.wr_w = 5; v.rw_w = 1; v.e_fa_e = 2'b10;
    add("fwd_e_m_priority", v);
    v.rw_m = 0; v.e_fa_e = 2'b01;
    add("fwd_e_w", v);
    v.rs_e = 0; v.e_fa_e = 2'b00;
    add("fwd_e_r0", v);
    v = '0; v.rs_e = 3; v.rt_e = 7; v.wr_m = 3; v.rw_m = 1; v.wr_w = 7; v.rw_w = 1;
    v.e_fa_e = 2'b10; v.e_fb_e = 2'b01;
    add("fwd_e_a_m_b_w", v);
    v = '0; v.rs_d = 9; v.rt_d = 10; v.wr_m = 9; v.rw_m = 1; v.e_fa_d = 1;
    add("fwd_d_a", v);
    v = '0; v.rt_d = 11; v.wr_m = 11; v.rw_m = 1; v.e_fb_d = 1;
    add("fwd_d_b", v);
    v = '0; v.wr_m = 0; v.rw_m = 1;
    add("fwd_d_r0", v);
    v = '0; v.m2r_e = 1; v.wr_e = 8; v.rt_d = 8; v.pc_src = 1; v.e_stall = 1;
    add("lw_stall_beats_flush", v);
    v = '0; v.m2r_e = 1; v.wr_e = 0;
    add("lw_r0_no_stall", v);
    v = '0; v.br = 1; v.pc_src = 1; v.rs_d = 4; v.rt_d = 6; v.e_flush_d = 1;
    add("branch_taken_clean", v);
    v.rw_e = 1; v.wr_e = 4; v.e_stall = 1; v.e_flush_d = 0;
    add("branch_e_hazard", v);
    v = '0; v.br = 1; v.rs_d = 4; v.rt_d = 6; v.m2r_m = 1; v.wr_m = 6; v.e_stall = 1;
    add("branch_m_load", v);
    v = '0; v.br = 1; v.pc_src = 1; v.rs_d = 4; v.rt_d = 6; v.rw_m = 1; v.wr_m = 6;
    v.e_fb_d = 1; v.e_flush_d = 1;
    add("branch_m_alu_fwd", v);
    v = '0; v.rw_e = 1; v.wr_e = 4; v.rs_d = 4;
    add("e_write_no_branch", v);
    v = '0; v.br = 1; v.pc_src = 1; v.rw_e = 1; v.wr_e = 0; v.e_flush_d = 1;
    add("branch_r0_no_stall", v);
  endtask

  task automatic apply(input vec_t v);
    clear_inputs();
    rs_d = v.rs_d; rt_d = v.rt_d; rs_e = v.rs_e; rt_e = v.rt_e;
    write_reg_e = v.wr_e; write_reg_m = v.wr_m; write_reg_w = v.wr_w;
    reg_write_e = v.rw_e; reg_write_m = v.rw_m; reg_write_w = v.rw_w;
    mem_to_reg_e = v.m2r_e; mem_to_reg_m = v.m2r_m;
    branch_d = v.br; pc_src_d = v.pc_src;
  endtask

  initial begin
    logic exp_sc_stall [5];
    logic exp_sc_go    [5];
    exp_sc_stall = '{1, 1, 1, 1, 0};
    exp_sc_go    = '{0, 0, 0, 1, 0};

    build_vectors();

    // Reset with competing events present
    clear_inputs();
    rst = 1; pc_src_d = 1; md_start_e = 1; syscall_e = 1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_stall_f", stall_f, 0);
    check("rst_stall_d", stall_d, 0);
    check("rst_flush_e", flush_e, 1);
    check("rst_flush_d", flush_d, 0);
    check("rst_md_busy", md_busy, 0);
    check("rst_syscall_go", syscall_go, 0);
    @(negedge clk);
    clear_inputs(); rst = 0;
    @(negedge clk); #1;
    check("post_rst_idle", stall_f, 0);
    check("post_rst_md_busy", md_busy, 0);

    // Table-driven combinational checks
    foreach (tv[i]) begin
      @(negedge clk);
      apply(tv[i]);
      #1;
      check({tn[i], ".stall_f"}, stall_f, tv[i].e_stall);
      check({tn[i], ".stall_d"}, stall_d, tv[i].e_stall);
      check({tn[i], ".flush_e"}, flush_e, tv[i].e_stall);
      check({tn[i], ".flush_d"}, flush_d, tv[i].e_flush_d);
      check({tn[i], ".fwd_a_d"}, forward_a_d, tv[i].e_fa_d);
      check({tn[i], ".fwd_b_d"}, forward_b_d, tv[i].e_fb_d);
      check({tn[i], ".fwd_a_e"}, forward_a_e, tv[i].e_fa_e);
      check({tn[i], ".fwd_b_e"}, forward_b_e, tv[i].e_fb_e);
    end

    // Mult/div busy window, with a restart attempt mid-busy
    @(negedge clk);
    clear_inputs(); md_start_e = 1; md_op_d = 1;
    #1;
    check("md_start_not_yet_busy", md_busy, 0);
    check("md_start_no_stall", stall_f, 0);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      md_start_e = (c == 2);
      #1;
      check($sformatf("md_busy_c%0d", c), md_busy, (c <= LAT));
      check($sformatf("md_stall_c%0d", c), stall_f, (c <= LAT));
    end

    // Syscall: issue cycle, two DRAIN cycles, FIRE, then idle
    @(negedge clk);
    clear_inputs(); pc_src_d = 1;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clk);
      syscall_e = (c == 0);
      #1;
      check($sformatf("sc_stall_c%0d", c), stall_f, exp_sc_stall[c]);
      check($sformatf("sc_go_c%0d", c), syscall_go, exp_sc_go[c]);
      check($sformatf("sc_flush_d_c%0d", c), flush_d, !exp_sc_stall[c]);
    end

    // Reset mid-DRAIN and mid-busy
    @(negedge clk);
    clear_inputs(); syscall_e = 1; md_start_e = 1;
    @(negedge clk);
    clear_inputs(); rst = 1; pc_src_d = 1;
    rs_e = 5; write_reg_m = 5; reg_write_m = 1;
    #1;
    check("rst_drain_stall_f", stall_f, 0);
    check("rst_drain_flush_e", flush_e, 1);
    check("rst_drain_flush_d", flush_d, 0);
    check("rst_drain_fwd_a_e", forward_a_e, 2'b10);
    @(negedge clk);
    clear_inputs(); rst = 0; md_op_d = 1;
    #1;
    check("rst_drain_idle", stall_f, 0);
    check("rst_drain_md_busy", md_busy, 0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1;
      check($sformatf("rst_drain_no_go_c%0d", c), syscall_go, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_control_unit.md
HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

Interface
REQ-001 The block SHALL have parameter MD_LATENCY, default 32, giving the mult/div busy duration in cycles (legal range 2..63).
REQ-002 clk  in  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 rs_d, rt_d  in  5 each  decode-stage source register numbers.
REQ-005 rs_e, rt_e  in  5 each  execute-stage source register numbers, from the D/E pipeline register.
REQ-006 write_reg_e, write_reg_m, write_reg_w  in  5 each  destination register for the E, M and W stages.
REQ-007 reg_write_e, reg_write_m, reg_write_w  in  1 each  destination-write enables for the E, M and W stages.
REQ-008 mem_to_reg_e, mem_to_reg_m  in  1 each  load indicators for the E and M stages.
REQ-009 branch_d  in  1  branch in decode; pc_src_d  in  1  branch taken.
REQ-010 md_start_e  in  1  mult/div issued in execute; md_op_d  in  1  mult/div/mfhi/mflo in decode.
REQ-011 syscall_e  in  1  syscall in execute.
REQ-012 stall_f, stall_d  out  1 each  hold the PC and the F/D register.
REQ-013 flush_d  out  1  clear the F/D register; flush_e  out  1  drives the D/E register sig_clr.
REQ-014 forward_a_d, forward_b_d  out  1 each  forward the M-stage result to the decode comparator.
REQ-015 forward_a_e, forward_b_e  out  2 each  ALU operand select: 00 = register file, 01 = W result, 10 = M result.
REQ-016 md_busy  out  1  mult/div unit busy; syscall_go  out  1  one-cycle syscall execute pulse.

Function
REQ-017 forward_a_e SHALL be 10 when rs_e!=0, rs_e==write_reg_m and reg_write_m; otherwise 01 when rs_e!=0, rs_e==write_reg_w and reg_write_w; otherwise 00. M SHALL have priority over W.
REQ-018 forward_b_e SHALL be derived identically from rt_e.
REQ-019 forward_a_d SHALL be 1 exactly when rs_d!=0, rs_d==write_reg_m and reg_write_m; forward_b_d SHALL be derived identically from rt_d. Both SHALL be combinational.
REQ-020 lw_stall SHALL be mem_to_reg_e AND write_reg_e!=0 AND (write_reg_e==rs_d OR write_reg_e==rt_d).
REQ-021 br_stall SHALL be branch_d AND either (a) reg_write_e with a nonzero write_reg_e matching rs_d or rt_d, or (b) mem_to_reg_m with a nonzero write_reg_m matching rs_d or rt_d.
REQ-022 md_busy behaviour: md_start_e while md_busy=0 SHALL load the counter to MD_LATENCY and raise md_busy on the next edge. md_busy SHALL stay high for exactly MD_LATENCY cycles, decrementing by 1 per cycle. md_start_e while busy SHALL be ignored (not restarted).
REQ-023 md_stall SHALL be md_op_d AND md_busy.
REQ-024 The syscall FSM SHALL have states IDLE, DRAIN and FIRE, with a 2-bit drain counter.
REQ-025 In IDLE, syscall_e=1 SHALL cause a transition to DRAIN with the counter loaded to 2.
REQ-026 In DRAIN, the counter SHALL decrement each cycle; reaching 0 SHALL cause a transition to FIRE.
REQ-027 FIRE SHALL assert syscall_go for exactly one cycle and return to IDLE.
REQ-028 sc_stall SHALL be 1 when state!=IDLE OR (state==IDLE AND syscall_e); syscall_e SHALL be ignored outside IDLE.
REQ-029 any_stall SHALL be lw_stall | br_stall | md_stall | sc_stall.
REQ-030 stall_f and stall_d SHALL both equal any_stall.
REQ-031 flush_e SHALL equal any_stall, inserting a bubble into E.
REQ-032 flush_d SHALL equal pc_src_d AND NOT any_stall.
REQ-033 The syscall in E SHALL reach M normally on DRAIN entry; only younger instructions SHALL be bubbled.

Reset
REQ-034 On a clk edge with rst=1, the FSM SHALL go to IDLE, the drain and md counters SHALL clear to 0, md_busy SHALL be 0 and syscall_go SHALL be 0; this SHALL take priority over all other events, including mid-DRAIN and mid-busy.
REQ-035 While rst=1, stall_f, stall_d and flush_d SHALL be 0 and flush_e SHALL be 1; forward outputs SHALL stay purely combinational.

Verification
REQ-036 rs_e=5, write_reg_m=5, reg_write_m=1, write_reg_w=5, reg_write_w=1 -> forward_a_e=10. Then drop reg_write_m -> forward_a_e=01. Then rs_e=0 -> forward_a_e=00.
REQ-037 mem_to_reg_e=1, write_reg_e=8, rt_d=8 -> stall_f=stall_d=flush_e=1 and flush_d=0 for that cycle, even with pc_src_d=1.
REQ-038 md_start_e pulse with MD_LATENCY=4 -> md_busy high for exactly 4 cycles. md_op_d=1 throughout -> stall for 4 cycles, released on the 5th. A second md_start_e mid-busy -> no extension.
REQ-039 syscall_e=1 in IDLE -> stall for 4 cycles: the syscall_e cycle, 2 DRAIN cycles and FIRE. syscall_go=1 only in the FIRE cycle.
REQ-040 rst asserted during DRAIN -> next cycle state IDLE, syscall_go never pulses, md_busy=0.
REQ-041 branch_d=1, pc_src_d=1, no hazards -> flush_d=1 and stall_f=0. Add reg_write_e=1 with write_reg_e==rs_d -> flush_d=0 and stall_f=1.
